// File: rtl/register_file.sv
// MIPS-style register file: two combinational read ports with write-through bypass,
// one write port, and a registered debug read port.
module register_file #(
    parameter int unsigned INST_SZ = 32,
    parameter int unsigned REG_SZ  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_reg_write,
    input  logic [REG_SZ-1:0]  i_write_reg,
    input  logic [INST_SZ-1:0] i_write_data,
    input  logic [REG_SZ-1:0]  i_read_reg_1,
    input  logic [REG_SZ-1:0]  i_read_reg_2,
    output logic [INST_SZ-1:0] o_read_data_1,
    output logic [INST_SZ-1:0] o_read_data_2,
    input  logic [REG_SZ-1:0]  i_dbg_addr,
    output logic [INST_SZ-1:0] o_dbg_data
);

    localparam int unsigned DEPTH = 2 ** REG_SZ;

    logic [INST_SZ-1:0] regs_q [DEPTH];
    logic [INST_SZ-1:0] dbg_data_q;
    logic               wr_en;
    logic [INST_SZ-1:0] rd_data_1;
    logic [INST_SZ-1:0] rd_data_2;

    // Reset held low also blocks the bypass, so readers see stored values during reset.
    assign wr_en = i_reset & i_enable & i_reg_write & (i_write_reg != '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            dbg_data_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[i_write_reg] <= i_write_data;
            end
            // Debug port sees committed storage only; it is not gated by i_enable.
            dbg_data_q <= (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];
        end
    end

    always_comb begin
        rd_data_1 = (i_read_reg_1 == '0) ? '0 : regs_q[i_read_reg_1];
        if (wr_en && (i_write_reg == i_read_reg_1)) begin
            rd_data_1 = i_write_data;
        end
    end

    always_comb begin
        rd_data_2 = (i_read_reg_2 == '0) ? '0 : regs_q[i_read_reg_2];
        if (wr_en && (i_write_reg == i_read_reg_2)) begin
            rd_data_2 = i_write_data;
        end
    end

    assign o_read_data_1 = rd_data_1;
    assign o_read_data_2 = rd_data_2;
    assign o_dbg_data    = dbg_data_q;

endmodule

// File: tb/tb_register_file.sv
// Directed and model-checked bench for register_file.
module tb_register_file;

    logic        i_clk;
    logic        i_reset;
    logic        i_enable;
    logic        i_reg_write;
    logic [4:0]  i_write_reg;
    logic [31:0] i_write_data;
    logic [4:0]  i_read_reg_1;
    logic [4:0]  i_read_reg_2;
    logic [31:0] o_read_data_1;
    logic [31:0] o_read_data_2;
    logic [4:0]  i_dbg_addr;
    logic [31:0] o_dbg_data;

    int errors;
    int checks;

    register_file #(
        .INST_SZ(32),
        .REG_SZ (5)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_reg_write  (i_reg_write),
        .i_write_reg  (i_write_reg),
        .i_write_data (i_write_data),
        .i_read_reg_1 (i_read_reg_1),
        .i_read_reg_2 (i_read_reg_2),
        .o_read_data_1(o_read_data_1),
        .o_read_data_2(o_read_data_2),
        .i_dbg_addr   (i_dbg_addr),
        .o_dbg_data   (o_dbg_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        tick();
        tick();
        i_reset = 1'b1;
        for (int a = 0; a < 32; a++) begin
            i_read_reg_1 = 5'(a);
            i_read_reg_2 = 5'(a);
            i_dbg_addr   = 5'(a);
            #1;
            checks++;
            if (o_read_data_1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd1 reg %0d: got %h want 00000000", a, o_read_data_1);
            end
            checks++;
            if (o_read_data_2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd2 reg %0d: got %h want 00000000", a, o_read_data_2);
            end
            tick();
            checks++;
            if (o_dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_dbg reg %0d: got %h want 00000000", a, o_dbg_data);
            end
        end
    endtask

    task automatic test_write_read();
        i_enable     = 1'b1;
        i_reg_write  = 1'b1;
        i_write_reg  = 5'd5;
        i_write_data = 32'hABCDEF01;
        tick();
        i_reg_write  = 1'b0;
        i_read_reg_1 = 5'd5;
        i_read_reg_2 = 5'd5;
        i_dbg_addr   = 5'd5;
        #1;
        checks++;
        if (o_read_data_1 !== 32'hABCDEF01) begin
            errors++;
            $display("FAIL write_read_rd1: got %h want abcdef01", o_read_data_1);
        end
        checks++;
        if (o_read_data_2 !== 32'hABCDEF01) begin
            errors++;
            $display("FAIL write_read_rd2: got %h want abcdef01", o_read_data_2);
        end
        tick();
        checks++;
        if (o_dbg_data !== 32'hABCDEF01) begin
            errors++;
            $display("FAIL write_read_dbg: got %h want abcdef01", o_dbg_data);
        end
    endtask

    task automatic test_bypass();
        i_reg_write  = 1'b1;
        i_write_reg  = 5'd9;
        i_write_data = 32'h12345678;
        i_read_reg_1 = 5'd8;
        i_read_reg_2 = 5'd9;
        i_dbg_addr   = 5'd9;
        #1;
        checks++;
        if (o_read_data_2 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_rd2: got %h want 12345678", o_read_data_2);
        end
        checks++;
        if (o_read_data_1 !== 32'h0) begin
            errors++;
            $display("FAIL bypass_rd1_other: got %h want 00000000", o_read_data_1);
        end
        i_read_reg_1 = 5'd9;
        #1;
        checks++;
        if (o_read_data_1 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_rd1_same: got %h want 12345678", o_read_data_1);
        end
        tick();
        // Debug port must have captured the old stored value, not the bypassed one.
        checks++;
        if (o_dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL bypass_dbg_nobypass: got %h want 00000000", o_dbg_data);
        end
        i_reg_write = 1'b0;
        #1;
        checks++;
        if (o_read_data_2 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_stored: got %h want 12345678", o_read_data_2);
        end
    endtask

    task automatic test_reg0();
        i_reg_write  = 1'b1;
        i_write_reg  = 5'd0;
        i_write_data = 32'hFFFFFFFF;
        i_read_reg_1 = 5'd0;
        i_read_reg_2 = 5'd0;
        i_dbg_addr   = 5'd0;
        #1;
        checks++;
        if (o_read_data_1 !== 32'h0 || o_read_data_2 !== 32'h0) begin
            errors++;
            $display("FAIL reg0_same: got %h/%h want 0/0", o_read_data_1, o_read_data_2);
        end
        tick();
        i_reg_write = 1'b0;
        #1;
        checks++;
        if (o_read_data_1 !== 32'h0 || o_read_data_2 !== 32'h0) begin
            errors++;
            $display("FAIL reg0_next: got %h/%h want 0/0", o_read_data_1, o_read_data_2);
        end
        checks++;
        if (o_dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL reg0_dbg: got %h want 00000000", o_dbg_data);
        end
    endtask

    task automatic test_enable();
        i_enable     = 1'b0;
        i_reg_write  = 1'b1;
        i_write_reg  = 5'd3;
        i_write_data = 32'hDEADBEEF;
        i_read_reg_1 = 5'd3;
        #1;
        checks++;
        if (o_read_data_1 !== 32'h0) begin
            errors++;
            $display("FAIL enable_low_bypass: got %h want 00000000", o_read_data_1);
        end
        tick();
        i_reg_write = 1'b0;
        #1;
        checks++;
        if (o_read_data_1 !== 32'h0) begin
            errors++;
            $display("FAIL enable_low_store: got %h want 00000000", o_read_data_1);
        end
        i_enable    = 1'b1;
        i_reg_write = 1'b1;
        #1;
        checks++;
        if (o_read_data_1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL enable_high_bypass: got %h want deadbeef", o_read_data_1);
        end
        tick();
        i_reg_write = 1'b0;
        #1;
        checks++;
        if (o_read_data_1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL enable_high_store: got %h want deadbeef", o_read_data_1);
        end
    endtask

    task automatic test_reset_priority();
        i_reg_write  = 1'b1;
        i_write_reg  = 5'd7;
        i_write_data = 32'h00000055;
        tick();
        i_reset      = 1'b0;
        i_write_data = 32'h00000001;
        i_read_reg_1 = 5'd7;
        i_read_reg_2 = 5'd5;
        i_dbg_addr   = 5'd5;
        #1;
        checks++;
        if (o_read_data_1 !== 32'h00000055) begin
            errors++;
            $display("FAIL rst_no_bypass: got %h want 00000055", o_read_data_1);
        end
        tick();
        i_reset     = 1'b1;
        i_reg_write = 1'b0;
        #1;
        checks++;
        if (o_read_data_1 !== 32'h0) begin
            errors++;
            $display("FAIL rst_prio_reg7: got %h want 00000000", o_read_data_1);
        end
        checks++;
        if (o_read_data_2 !== 32'h0) begin
            errors++;
            $display("FAIL rst_clear_reg5: got %h want 00000000", o_read_data_2);
        end
        checks++;
        if (o_dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_clear_dbg: got %h want 00000000", o_dbg_data);
        end
        i_reg_write  = 1'b1;
        i_write_data = 32'h00000002;
        tick();
        i_reg_write = 1'b0;
        #1;
        checks++;
        if (o_read_data_1 !== 32'h00000002) begin
            errors++;
            $display("FAIL rst_first_write: got %h want 00000002", o_read_data_1);
        end
    endtask

    task automatic test_random();
        logic [31:0] model [32];
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] exp_dbg;
        logic        wq;
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int n = 0; n < 1000; n++) begin
            i_reset      = ($urandom_range(0, 49) != 0);
            i_enable     = ($urandom_range(0, 3) != 0);
            i_reg_write  = ($urandom_range(0, 2) != 0);
            i_write_reg  = 5'($urandom_range(0, 31));
            i_write_data = $urandom;
            i_read_reg_1 = 5'($urandom_range(0, 31));
            i_read_reg_2 = ($urandom_range(0, 3) == 0) ? i_write_reg : 5'($urandom_range(0, 31));
            i_dbg_addr   = 5'($urandom_range(0, 31));
            wq = i_reset && i_enable && i_reg_write && (i_write_reg != 5'd0);
            exp1 = (wq && i_write_reg == i_read_reg_1) ? i_write_data : model[i_read_reg_1];
            exp2 = (wq && i_write_reg == i_read_reg_2) ? i_write_data : model[i_read_reg_2];
            exp_dbg = i_reset ? model[i_dbg_addr] : 32'h0;
            #1;
            checks++;
            if (o_read_data_1 !== exp1) begin
                errors++;
                $display("FAIL rand_rd1 cyc %0d: got %h want %h", n, o_read_data_1, exp1);
            end
            checks++;
            if (o_read_data_2 !== exp2) begin
                errors++;
                $display("FAIL rand_rd2 cyc %0d: got %h want %h", n, o_read_data_2, exp2);
            end
            if (!i_reset) begin
                for (int i = 0; i < 32; i++) model[i] = 32'h0;
            end else if (wq) begin
                model[i_write_reg] = i_write_data;
            end
            tick();
            checks++;
            if (o_dbg_data !== exp_dbg) begin
                errors++;
                $display("FAIL rand_dbg cyc %0d: got %h want %h", n, o_dbg_data, exp_dbg);
            end
        end
        i_reset     = 1'b1;
        i_reg_write = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        i_reset      = 1'b0;
        i_enable     = 1'b0;
        i_reg_write  = 1'b0;
        i_write_reg  = 5'd0;
        i_write_data = 32'h0;
        i_read_reg_1 = 5'd0;
        i_read_reg_2 = 5'd0;
        i_dbg_addr   = 5'd0;
        test_reset();
        test_write_read();
        test_bypass();
        test_reg0();
        test_enable();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter INST_SZ, default 32, SHALL set data word width in bits.
REQ-002 Parameter REG_SZ, default 5, SHALL set register address width; depth SHALL be 2**REG_SZ (32 registers).
REQ-003 Port i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port i_enable  input  1  SHALL gate all writes (low = pipeline halted by debug unit).
REQ-006 Port i_reg_write  input  1  SHALL request a write from WB stage.
REQ-007 Port i_write_reg  input  REG_SZ  SHALL give the write address.
REQ-008 Port i_write_data  input  INST_SZ  SHALL give the write data.
REQ-009 Port i_read_reg_1  input  REG_SZ  SHALL give the rs read address.
REQ-010 Port i_read_reg_2  input  REG_SZ  SHALL give the rt read address.
REQ-011 Port o_read_data_1  output  INST_SZ  SHALL give rs data to ID operand path and branch comparator.
REQ-012 Port o_read_data_2  output  INST_SZ  SHALL give rt data to ID operand path and branch comparator.
REQ-013 Port i_dbg_addr  input  REG_SZ  SHALL give the debug-unit read address.
REQ-014 Port o_dbg_data  output  INST_SZ  SHALL give registered debug read data.

Function
REQ-015 Storage SHALL be 2**REG_SZ words of INST_SZ bits.
REQ-016 Write SHALL occur at rising edge when i_reset=1, i_enable=1, i_reg_write=1, i_write_reg!=0.
REQ-017 Writes to register 0 SHALL be discarded; register 0 SHALL always read 0.
REQ-018 Read ports 1/2 SHALL be combinational (zero-cycle latency from address to data).
REQ-019 Write-through bypass: if a write qualifies per REQ-016 this cycle and i_write_reg equals a read address, that port SHALL output i_write_data in the same cycle.
REQ-020 Bypass SHALL NOT apply when i_write_reg=0, i_enable=0, or i_reg_write=0; stored value SHALL be output instead.
REQ-021 Both read ports SHALL bypass independently; same address on both ports SHALL give identical data.
REQ-022 o_dbg_data SHALL register storage[i_dbg_addr] each rising edge (one-cycle latency), no bypass, independent of i_enable.
REQ-023 i_dbg_addr=0 SHALL yield o_dbg_data=0 the following cycle.
REQ-024 Read/write ports SHALL NOT stall or handshake; module SHALL accept one write and three reads per cycle.

Reset
REQ-025 While i_reset=0 at a rising edge, all registers SHALL clear to 0 and o_dbg_data SHALL clear to 0.
REQ-026 Reset SHALL take priority over a simultaneous write; the write SHALL be lost.
REQ-027 During reset, bypass SHALL be disabled; o_read_data_1/2 SHALL reflect stored (zero after first reset edge) values.
REQ-028 Reset asserted mid-operation SHALL clear all prior contents in one edge; first write SHALL be accepted at the first edge with i_reset=1.

Verification
REQ-029 Reset 2 cycles, read regs 0..31 on both ports and debug port -> all 32'h00000000.
REQ-030 Write reg 5=32'hABCDEF01 (enable=1), next cycle read_reg_1=5, read_reg_2=5 -> both 32'hABCDEF01; debug addr 5 -> 32'hABCDEF01 one cycle later.
REQ-031 Same-cycle write reg 9=32'h12345678 with read_reg_2=9 -> o_read_data_2=32'h12345678 that cycle (bypass); read_reg_1=8 -> stored 0.
REQ-032 Write reg 0=32'hFFFFFFFF -> read reg 0 returns 0 same and next cycle; no bypass.
REQ-033 i_enable=0, write reg 3=32'hDEADBEEF -> reg 3 stays 0, no bypass; repeat with i_enable=1 -> 32'hDEADBEEF.
REQ-034 Write reg 7=32'h1 with i_reset=0 same edge -> reg 7 reads 0 after reset releases; randomized writes/reads vs. reference model for 1000 cycles -> zero mismatches.
